cam_capture_ctrl: RTL and testbench
===================================

// Module: cam_capture_ctrl
// PURPOSE
//  Parametrised capture controller for the CMOS camera parallel bus (pclk/vsync/href).
//  Generates ring-buffer write addresses and a per-byte write strobe.
//  Raises a segment interrupt each time SEG_BYTES bytes are written, with host ack/flow control,
//  overflow detection, line/frame counting and line-length checking.
//  Sits between the sensor pins and the line buffer RAM / host interrupt logic.
// PARAMETERS
//  ADDR_W         11    buffer address width; buffer holds NSEG=floor(2**ADDR_W/SEG_BYTES) segments
//  SEG_BYTES      780   bytes per segment (one dataInterrupt each); NSEG>=2 required
//  LINE_BYTES     1560  expected bytes per href line (used for line_err only)
//  LINE_W         10    line counter width
//  FRAME_W        8     frame counter width
//  VSYNC_ACT_HIGH 1     1: vsync active-high; 0: active-low (normalised internally)
// PORTS
//  pclk           in   1        pixel clock; sole clock, all logic on rising edge
//  rst            in   1        asynchronous, active-high reset
//  vsync          in   1        sensor frame sync (polarity per VSYNC_ACT_HIGH)
//  href           in   1        sensor line valid; one byte per pclk while high
//  seg_ack        in   1        one-cycle pulse: host has drained one segment
//  address        out  ADDR_W   buffer address for the current byte (registered)
//  wr_en          out  1        combinational: href & ~vs_act; write byte at address
//  dataInterrupt  out  1        one-cycle pulse: a segment completed
//  seg_base       out  ADDR_W   start address of the last completed segment; held until the next
//  pending        out  $clog2(NSEG+1)  completed-but-unacked segments
//  overflow       out  1        sticky; set when a segment completes with pending==NSEG
//  frameInterrupt out  1        registered normalised vsync level (vs_act)
//  frame_start    out  1        one-cycle pulse on vs_act rising edge
//  line_count     out  LINE_W   lines completed this frame
//  frame_count    out  FRAME_W  frames started since reset; wraps modulo 2**FRAME_W
//  line_err       out  1        one-cycle pulse: ended line byte count != LINE_BYTES
// BEHAVIOUR
//  - Reset: every register and output is 0 (wr_en follows href & ~vs_act).
//    Edge-detect history is cleared. href high at release: no line start seen;
//    the line's end is still counted and checked (line_err expected).
//  - Byte accepted on each pclk where wr_en=1.
//    address advances by 1 the next cycle and wraps NSEG*SEG_BYTES-1 -> 0.
//  - seg_cnt counts accepted bytes 0..SEG_BYTES-1 and continues across lines.
//    On the byte with seg_cnt==SEG_BYTES-1: seg_cnt<=0;
//    next cycle dataInterrupt=1 and seg_base = that segment's first address.
//  - pending: +1 on completion, -1 on seg_ack. Both in one cycle: unchanged, no overflow.
//    Completion at pending==NSEG without ack: pending stays NSEG, overflow<=1.
//    seg_ack at pending==0: ignored.
//  - Line end = href falling edge (registered detect).
//    One cycle later: line_count+1 (saturates at all-ones); line_err=1 if line_bytes!=LINE_BYTES.
//    line_bytes clears at line end and saturates at its max.
//  - vs_act rising edge, acted on in the cycle after detection:
//    frame_start=1, frame_count+1. Zero address, seg_cnt, line_count, line_bytes, pending, overflow.
//    Any partial segment is discarded without an interrupt.
//    Bytes while vs_act=1: not accepted.
//  - vs_act edge coincident with a segment completion: the frame reset wins;
//    that dataInterrupt still fires with its seg_base.
//  - rst mid-line or mid-frame: immediate clear. Capture resumes at the next accepted byte at address 0.
// STRUCTURE
//  - cam_pkg: NSEG and pending width derivation, VSYNC polarity normalise function.
//  - Sub-module cam_edge_det: 2-flop history with rise/fall pulses, async reset.
//    Instanced for href and vs_act.
//  - Remaining counters and the pending/overflow logic live in this module.
// TESTING (defaults: NSEG=2)
//  1 rst pulse mid-line at address 300 -> all outputs 0 same edge; next line writes from 0.
//  2 One 1560-byte line -> dataInterrupt after byte 780 (seg_base 0) and 1560 (seg_base 780);
//    pending=2; line_count=1; no line_err; address back to 0.
//  3 Continue a third segment, no ack -> overflow=1, pending=2; then seg_ack -> pending=1.
//  4 seg_ack coincident with completion at pending=2 -> pending=2, overflow stays 0.
//  5 1000-byte line -> one interrupt at byte 780; line_err pulse.
//    Then vsync -> frame_start, frame_count+1, address 0, pending 0, 220-byte residue dropped.
//  6 VSYNC_ACT_HIGH=0: vsync held low -> wr_en=0 and no interrupts; frameInterrupt=1.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared derivations for the camera capture controller: segment count,
// pending-counter width and vsync polarity normalisation.
package cam_pkg;

  function automatic int unsigned calc_nseg(input int unsigned addr_w,
                                            input int unsigned seg_bytes);
    return (32'd1 << addr_w) / seg_bytes;
  endfunction

  function automatic int unsigned calc_pend_w(input int unsigned nseg);
    return $clog2(nseg + 1);
  endfunction

  function automatic logic vsync_norm(input logic vsync, input bit act_high);
    return act_high ? vsync : ~vsync;
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_edge_det.sv
// Two-flop history edge detector: level is the registered input, rise/fall
// pulse for one cycle after the registered level changes.
module cam_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= din;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera parallel-bus capture controller: ring-buffer addressing, segment
// interrupts with host flow control, line/frame counting and line checks.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned SEG_BYTES      = 780,
  parameter int unsigned LINE_BYTES     = 1560,
  parameter int unsigned LINE_W         = 10,
  parameter int unsigned FRAME_W        = 8,
  parameter int unsigned VSYNC_ACT_HIGH = 1,
  localparam int unsigned NSEG          = calc_nseg(ADDR_W, SEG_BYTES),
  localparam int unsigned PEND_W        = calc_pend_w(NSEG)
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               href,
  input  logic               seg_ack,
  output logic [ADDR_W-1:0]  address,
  output logic               wr_en,
  output logic               dataInterrupt,
  output logic [ADDR_W-1:0]  seg_base,
  output logic [PEND_W-1:0]  pending,
  output logic               overflow,
  output logic               frameInterrupt,
  output logic               frame_start,
  output logic [LINE_W-1:0]  line_count,
  output logic [FRAME_W-1:0] frame_count,
  output logic               line_err
);

  localparam int unsigned SEG_W = $clog2(SEG_BYTES);
  localparam int unsigned LB_W  = $clog2(LINE_BYTES + 2);

  logic              vs_act;
  logic              href_fall;
  logic              vs_rise;
  logic              unused_href_level;
  logic              unused_href_rise;
  logic              unused_vs_fall;
  logic [SEG_W-1:0]  seg_cnt;
  logic [LB_W-1:0]   line_bytes;
  logic              seg_done;
  logic              addr_last;
  logic              ack_ok;

  assign vs_act = vsync_norm(vsync, VSYNC_ACT_HIGH != 0);

  cam_edge_det u_href_edge (
    .clk   (pclk),
    .rst   (rst),
    .din   (href),
    .level (unused_href_level),
    .rise  (unused_href_rise),
    .fall  (href_fall)
  );

  cam_edge_det u_vs_edge (
    .clk   (pclk),
    .rst   (rst),
    .din   (vs_act),
    .level (frameInterrupt),
    .rise  (vs_rise),
    .fall  (unused_vs_fall)
  );

  assign wr_en     = href & ~vs_act;
  assign seg_done  = wr_en && (seg_cnt == SEG_W'(SEG_BYTES - 1));
  assign addr_last = (address == ADDR_W'(NSEG * SEG_BYTES - 1));
  assign ack_ok    = seg_ack && (pending != '0);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      address       <= '0;
      seg_cnt       <= '0;
      dataInterrupt <= 1'b0;
      seg_base      <= '0;
      pending       <= '0;
      overflow      <= 1'b0;
      frame_start   <= 1'b0;
      line_count    <= '0;
      frame_count   <= '0;
      line_bytes    <= '0;
      line_err      <= 1'b0;
    end else begin
      dataInterrupt <= seg_done;
      frame_start   <= vs_rise;
      line_err      <= 1'b0;
      // Segments are SEG_BYTES-aligned from 0, so the completing byte's
      // address minus SEG_BYTES-1 is always the segment's first address.
      if (seg_done) seg_base <= address - ADDR_W'(SEG_BYTES - 1);

      if (vs_rise) begin
        frame_count <= frame_count + FRAME_W'(1);
        address     <= '0;
        seg_cnt     <= '0;
        line_count  <= '0;
        line_bytes  <= '0;
        pending     <= '0;
        overflow    <= 1'b0;
      end else begin
        if (wr_en) begin
          address <= addr_last ? '0 : address + ADDR_W'(1);
          seg_cnt <= seg_done ? '0 : seg_cnt + SEG_W'(1);
        end

        if (seg_done && !ack_ok) begin
          if (pending == PEND_W'(NSEG)) overflow <= 1'b1;
          else                          pending  <= pending + PEND_W'(1);
        end else if (!seg_done && ack_ok) begin
          pending <= pending - PEND_W'(1);
        end

        if (href_fall) begin
          if (line_count != '1) line_count <= line_count + LINE_W'(1);
          line_err   <= (line_bytes != LB_W'(LINE_BYTES));
          line_bytes <= wr_en ? LB_W'(1) : '0;
        end else if (wr_en && line_bytes != '1) begin
          line_bytes <= line_bytes + LB_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed self-checking bench for cam_capture_ctrl (default parameters plus
// an active-low vsync instance).
module tb_cam_capture_ctrl;

  logic        pclk;
  logic        rst;
  logic        vsync, href, seg_ack;
  logic [10:0] address, seg_base;
  logic        wr_en, dataInterrupt, overflow, frameInterrupt, frame_start, line_err;
  logic [1:0]  pending;
  logic [9:0]  line_count;
  logic [7:0]  frame_count;

  logic        vsync2, href2, seg_ack2;
  logic [10:0] address2, seg_base2;
  logic        wr_en2, dataInterrupt2, overflow2, frameInterrupt2, frame_start2, line_err2;
  logic [1:0]  pending2;
  logic [9:0]  line_count2;
  logic [7:0]  frame_count2;

  int checks = 0;
  int errors = 0;

  cam_capture_ctrl dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .seg_ack(seg_ack),
    .address(address), .wr_en(wr_en), .dataInterrupt(dataInterrupt),
    .seg_base(seg_base), .pending(pending), .overflow(overflow),
    .frameInterrupt(frameInterrupt), .frame_start(frame_start),
    .line_count(line_count), .frame_count(frame_count), .line_err(line_err)
  );

  cam_capture_ctrl #(.VSYNC_ACT_HIGH(0)) dut2 (
    .pclk(pclk), .rst(rst), .vsync(vsync2), .href(href2), .seg_ack(seg_ack2),
    .address(address2), .wr_en(wr_en2), .dataInterrupt(dataInterrupt2),
    .seg_base(seg_base2), .pending(pending2), .overflow(overflow2),
    .frameInterrupt(frameInterrupt2), .frame_start(frame_start2),
    .line_count(line_count2), .frame_count(frame_count2), .line_err(line_err2)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; seg_ack = 1'b0;
    vsync2 = 1'b0; href2 = 1'b0; seg_ack2 = 1'b0;
    #1;
    chk("rst_address", 32'(address), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_dint", 32'(dataInterrupt), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_frameint2", 32'(frameInterrupt2), 0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // 1: reset mid-line at address 300
    href = 1'b1;
    repeat (300) step();
    chk("t1_addr300", 32'(address), 300);
    rst = 1'b1;
    #1;
    chk("t1_rst_addr", 32'(address), 0);
    chk("t1_rst_frame_count2", 32'(frame_count2), 0);
    chk("t1_rst_wr_en_follows", 32'(wr_en), 1);
    rst = 1'b0; href = 1'b0;
    repeat (3) step();
    chk("t1_no_line_end", 32'(line_count), 0);
    chk("t1_addr_idle", 32'(address), 0);

    // 2: one 1560-byte line
    href = 1'b1;
    #1;
    chk("t2_start_addr", 32'(address), 0);
    repeat (780) step();
    chk("t2_dint1", 32'(dataInterrupt), 1);
    chk("t2_base1", 32'(seg_base), 0);
    chk("t2_pend1", 32'(pending), 1);
    chk("t2_addr780", 32'(address), 780);
    step();
    chk("t2_dint_pulse", 32'(dataInterrupt), 0);
    repeat (779) step();
    chk("t2_dint2", 32'(dataInterrupt), 1);
    chk("t2_base2", 32'(seg_base), 780);
    chk("t2_pend2", 32'(pending), 2);
    chk("t2_addr_wrap", 32'(address), 0);
    href = 1'b0;
    step();
    chk("t2_line_cnt_early", 32'(line_count), 0);
    step();
    chk("t2_line_cnt", 32'(line_count), 1);
    chk("t2_line_err", 32'(line_err), 0);
    chk("t2_ovf", 32'(overflow), 0);

    // 3: third segment without ack
    href = 1'b1;
    repeat (780) step();
    chk("t3_dint", 32'(dataInterrupt), 1);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_pend", 32'(pending), 2);
    href = 1'b0;
    repeat (2) step();
    chk("t3_line_err", 32'(line_err), 1);
    chk("t3_line_cnt", 32'(line_count), 2);
    step();
    chk("t3_line_err_pulse", 32'(line_err), 0);
    seg_ack = 1'b1;
    step();
    seg_ack = 1'b0;
    chk("t3_ack_pend", 32'(pending), 1);
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // frame boundary clears overflow
    vsync = 1'b1;
    step();
    chk("f1_frameint", 32'(frameInterrupt), 1);
    chk("f1_pend_before", 32'(pending), 1);
    step();
    chk("f1_frame_start", 32'(frame_start), 1);
    chk("f1_frame_count", 32'(frame_count), 1);
    chk("f1_pend_clr", 32'(pending), 0);
    chk("f1_ovf_clr", 32'(overflow), 0);
    chk("f1_addr_clr", 32'(address), 0);
    chk("f1_line_clr", 32'(line_count), 0);
    step();
    chk("f1_fs_pulse", 32'(frame_start), 0);
    vsync = 1'b0;
    step();

    // 4: ack coincident with completion at pending==NSEG
    href = 1'b1;
    repeat (1560) step();
    chk("t4_pend_full", 32'(pending), 2);
    repeat (779) step();
    seg_ack = 1'b1;
    step();
    seg_ack = 1'b0;
    chk("t4_pend", 32'(pending), 2);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_dint", 32'(dataInterrupt), 1);
    chk("t4_base", 32'(seg_base), 0);
    href = 1'b0;
    repeat (2) step();
    chk("t4_line_err", 32'(line_err), 1);

    // 5: drain (extra ack at 0 ignored), 1000-byte line, vsync drops residue
    seg_ack = 1'b1;
    step();
    chk("t5_ack1", 32'(pending), 1);
    step();
    chk("t5_ack2", 32'(pending), 0);
    step();
    seg_ack = 1'b0;
    chk("t5_ack_at_zero", 32'(pending), 0);
    href = 1'b1;
    repeat (780) step();
    chk("t5_dint", 32'(dataInterrupt), 1);
    chk("t5_base", 32'(seg_base), 780);
    chk("t5_pend", 32'(pending), 1);
    repeat (220) step();
    chk("t5_addr", 32'(address), 220);
    href = 1'b0;
    repeat (2) step();
    chk("t5_line_err", 32'(line_err), 1);
    chk("t5_line_cnt", 32'(line_count), 2);
    vsync = 1'b1;
    repeat (2) step();
    chk("t5_frame_start", 32'(frame_start), 1);
    chk("t5_frame_count", 32'(frame_count), 2);
    chk("t5_addr_clr", 32'(address), 0);
    chk("t5_pend_clr", 32'(pending), 0);
    vsync = 1'b0;
    step();
    href = 1'b1;
    repeat (560) step();
    chk("t5_residue_dropped", 32'(dataInterrupt), 0);
    chk("t5_residue_pend", 32'(pending), 0);
    repeat (220) step();
    chk("t5_new_seg_dint", 32'(dataInterrupt), 1);
    chk("t5_new_seg_base", 32'(seg_base), 0);
    href = 1'b0;
    step();

    // 6: active-low vsync held low blocks capture
    href2 = 1'b1;
    #1;
    chk("t6_wr_en", 32'(wr_en2), 0);
    chk("t6_frameint", 32'(frameInterrupt2), 1);
    chk("t6_frame_count", 32'(frame_count2), 1);
    repeat (800) step();
    chk("t6_dint", 32'(dataInterrupt2), 0);
    chk("t6_pend", 32'(pending2), 0);
    chk("t6_addr", 32'(address2), 0);
    href2 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
